// File: rtl/mem_port_arbiter.sv
// Arbitrates the single shared memory port between fetch (I) and data (D) requesters.
// Define ARB_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES busy cycles without mem_ack.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic                  d_we,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_sel,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_nxt;
    logic                sel_nxt;
    logic                busy;
    logic                timeout;
    logic                done;

    assign busy = (state != IDLE);
    assign done = busy && (mem_ack || timeout);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;

    // Fires in the TIMEOUT_CYCLES-th busy cycle; a same-cycle mem_ack takes precedence.
    assign timeout = busy && !mem_ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !busy || done) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // State register; mem_sel is registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            streak  <= '0;
            mem_sel <= 1'b0;
        end else begin
            state   <= state_nxt;
            streak  <= streak_nxt;
            mem_sel <= sel_nxt;
        end
    end

    // Next state: data wins unless fetch has waited through MAX_D_STREAK data grants.
    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || (streak < STREAK_W'(MAX_D_STREAK)))) begin
                    state_nxt  = BUSY_D;
                    streak_nxt = i_req ? (streak + 1'b1) : '0;
                end else if (i_req) begin
                    state_nxt  = BUSY_I;
                    streak_nxt = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        sel_nxt = (state_nxt == BUSY_D);
    end

    // Port mux and completion routing.
    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_wstrb = '0;
        i_ack     = 1'b0;
        i_rdata   = '0;
        i_err     = 1'b0;
        d_ack     = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        if (busy) begin
            mem_req  = 1'b1;
            mem_addr = mem_sel ? d_addr : i_addr;
            if (mem_sel) begin
                mem_we    = d_we;
                mem_wdata = d_wdata;
                mem_wstrb = d_wstrb;
            end
        end
        if (done) begin
            if (mem_sel) begin
                d_ack   = 1'b1;
                d_err   = timeout;
                d_rdata = mem_ack ? mem_rdata : '0;
            end else begin
                i_ack   = 1'b1;
                i_err   = timeout;
                i_rdata = mem_ack ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of the port.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned MAXS   = 4;
    localparam int unsigned TO     = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int unsigned MAX_LAT = TO_EN ? 10 : 5;

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic              mem_req;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .MAX_D_STREAK  (MAXS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_req  (mem_req),
        .mem_sel  (mem_sel),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Grant history: was it a data grant, and was fetch waiting when it was made.
    typedef struct packed {
        logic is_d;
        logic i_wait;
    } grant_t;
    grant_t glog[$];

    function automatic int d_run();
        int n = 0;
        for (int k = glog.size() - 1; k >= 0; k--) begin
            if (glog[k].is_d && glog[k].i_wait) n++;
            else break;
        end
        return n;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, 64'(mem_req), 64'(0));
        check({tag, "_mem_sel"}, 64'(mem_sel), 64'(0));
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'(0));
        check({tag, "_i_ack"}, 64'(i_ack), 64'(0));
        check({tag, "_i_rdata"}, 64'(i_rdata), 64'(0));
        check({tag, "_i_err"}, 64'(i_err), 64'(0));
        check({tag, "_d_ack"}, 64'(d_ack), 64'(0));
        check({tag, "_d_rdata"}, 64'(d_rdata), 64'(0));
        check({tag, "_d_err"}, 64'(d_err), 64'(0));
    endtask

    logic        pre_i, pre_d, pre_ack, pre_rst, pre_to;
    logic        m_busy, m_owner, after_rst;
    int          m_cycles, lat, grants;
    logic        exp_to, exp_iack, exp_dack;
    grant_t      g;

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_we = 1'b0;
        d_wdata = '0; d_wstrb = '0; mem_ack = 1'b0; mem_rdata = '0;
        m_busy = 1'b0; m_owner = 1'b0; m_cycles = 0; lat = 0; pre_to = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            pre_i = i_req; pre_d = d_req; pre_ack = mem_ack; pre_rst = rst;
            @(posedge clk);
            #1;
            rst = 1'b0;
            after_rst = pre_rst;
            if (pre_rst) begin
                m_busy = 1'b0;
                glog.delete();
            end else if (m_busy) begin
                if (pre_ack || pre_to) m_busy = 1'b0;
                else m_cycles++;
            end else if (pre_i || pre_d) begin
                m_owner = pre_d && (!pre_i || d_run() < int'(MAXS));
                g.is_d = m_owner; g.i_wait = pre_i;
                glog.push_back(g);
                if (glog.size() > 16) void'(glog.pop_front());
                m_busy = 1'b1; m_cycles = 1;
                lat = int'($urandom_range(0, MAX_LAT));
            end

            check("mem_req", 64'(mem_req), 64'(m_busy));
            check("mem_sel", 64'(mem_sel), 64'(m_busy && m_owner));

            mem_rdata = $urandom();
            if (m_busy) mem_ack = (m_cycles - 1 == lat);
            else mem_ack = after_rst || ($urandom_range(0, 7) == 0);
            #1;
            exp_to   = TO_EN && m_busy && !mem_ack && (m_cycles == int'(TO));
            exp_iack = m_busy && !m_owner && (mem_ack || exp_to);
            exp_dack = m_busy && m_owner && (mem_ack || exp_to);
            check("i_ack", 64'(i_ack), 64'(exp_iack));
            check("d_ack", 64'(d_ack), 64'(exp_dack));
            check("i_rdata", 64'(i_rdata), 64'((exp_iack && mem_ack) ? mem_rdata : '0));
            check("d_rdata", 64'(d_rdata), 64'((exp_dack && mem_ack) ? mem_rdata : '0));
            check("i_err", 64'(i_err), 64'(exp_iack && exp_to));
            check("d_err", 64'(d_err), 64'(exp_dack && exp_to));
            check("mem_addr", 64'(mem_addr), 64'(m_busy ? (m_owner ? d_addr : i_addr) : '0));
            check("mem_we", 64'(mem_we), 64'(m_busy && m_owner && d_we));
            check("mem_wstrb", 64'(mem_wstrb), 64'((m_busy && m_owner) ? d_wstrb : '0));
            if (m_busy && m_owner) check("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
            else if (!m_busy) check("mem_wdata_idle", 64'(mem_wdata), 64'(0));
            pre_to = exp_to;

            if (exp_iack) i_req = 1'b0;
            if (exp_dack) d_req = 1'b0;
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req   = 1'b1;
                d_addr  = $urandom();
                d_we    = 1'($urandom());
                d_wdata = $urandom();
                d_wstrb = STRB_W'($urandom());
            end
            rst = ($urandom_range(0, 199) == 0);
        end

        // Both requesters saturated with zero-wait memory: D,D,D,D,I repeating.
        rst = 1'b1; mem_ack = 1'b0; i_req = 1'b1; d_req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_mem_req", 64'(mem_req), 64'(0));
        grants = 0;
        for (int c = 0; c < 40 && grants < 10; c++) begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                check("grant_seq", 64'(mem_sel), 64'((grants % (MAXS + 1)) != MAXS));
                grants++;
                mem_ack = 1'b1;
                mem_rdata = $urandom();
            end else begin
                mem_ack = 1'b0;
            end
        end
        check("grant_cnt", 64'(grants), 64'(10));
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
